// File: rtl/mux_arbiter_if.sv
// rtl/mux_arbiter_if.sv - request/release/grant bundle between two requesters and the mux arbiter
interface mux_arbiter_if;
  logic req_a;
  logic req_b;
  logic rel_a;
  logic rel_b;
  logic gnt_a;
  logic gnt_b;
  logic sel;
  logic busy;
  logic timeout;

  modport master (
    output req_a, req_b, rel_a, rel_b,
    input  gnt_a, gnt_b, sel, busy, timeout
  );

  modport slave (
    input  req_a, req_b, rel_a, rel_b,
    output gnt_a, gnt_b, sel, busy, timeout
  );
endinterface

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester round-robin arbiter for a shared mux with hold limit and guard gap
module mux_arbiter #(
  parameter int unsigned HOLD_MAX  = 8,
  parameter int unsigned GUARD_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GUARD} state_t;

  localparam logic [7:0] HOLD_LIM  = 8'(HOLD_MAX);
  localparam logic [3:0] GUARD_LIM = 4'(GUARD_CYC);

  state_t     r_state;
  logic [7:0] r_hold_cnt;
  logic [3:0] r_guard_cnt;
  logic       r_last_b;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic       r_sel;
  logic       r_busy;
  logic       r_timeout;

  logic       w_vol_rel;
  logic       w_other_req;
  logic       w_hold_expired;

  always_comb begin
    w_vol_rel      = 1'b0;
    w_other_req    = 1'b0;
    w_hold_expired = (r_hold_cnt >= HOLD_LIM);
    if (r_state == OWN_A) begin
      w_vol_rel   = bus.rel_a | ~bus.req_a;
      w_other_req = bus.req_b;
    end else if (r_state == OWN_B) begin
      w_vol_rel   = bus.rel_b | ~bus.req_b;
      w_other_req = bus.req_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold_cnt  <= 8'd0;
      r_guard_cnt <= 4'd0;
      r_last_b    <= 1'b1;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          // On a tie the requester that did not own the mux last wins.
          if (bus.req_a && (!bus.req_b || r_last_b)) begin
            r_state    <= OWN_A;
            r_gnt_a    <= 1'b1;
            r_sel      <= 1'b0;
            r_busy     <= 1'b1;
            r_last_b   <= 1'b0;
            r_hold_cnt <= 8'd1;
          end else if (bus.req_b) begin
            r_state    <= OWN_B;
            r_gnt_b    <= 1'b1;
            r_sel      <= 1'b1;
            r_busy     <= 1'b1;
            r_last_b   <= 1'b1;
            r_hold_cnt <= 8'd1;
          end
        end
        OWN_A, OWN_B: begin
          if (w_vol_rel || (w_hold_expired && w_other_req)) begin
            r_state     <= GUARD;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_guard_cnt <= 4'd1;
            r_timeout   <= ~w_vol_rel;
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        GUARD: begin
          if (r_guard_cnt >= GUARD_LIM) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_guard_cnt <= r_guard_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt_a <= 1'b0;
          r_gnt_b <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_a   = r_gnt_a;
  assign bus.gnt_b   = r_gnt_b;
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - scoreboard bench for mux_arbiter: directed scenarios, contention and random streams
module tb_mux_arbiter;
  localparam int HOLD_MAX  = 8;
  localparam int GUARD_CYC = 1;

  typedef struct packed {
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic busy;
    logic timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mux_arbiter_if bus ();

  mux_arbiter #(.HOLD_MAX(HOLD_MAX), .GUARD_CYC(GUARD_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: 0 idle, 1 A owns, 2 B owns, 3 guard
  int m_st     = 0;
  int m_held   = 0;
  int m_gleft  = 0;
  bit m_last_b = 1'b1;
  bit m_sel    = 1'b0;
  bit m_to     = 1'b0;

  task automatic model_step(input bit ra, input bit rb, input bit la, input bit lb, input bit rs);
    bit mine_req, mine_rel, other;
    if (rs) begin
      m_st = 0; m_held = 0; m_gleft = 0; m_last_b = 1'b1; m_sel = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      case (m_st)
        0: begin
          if (ra && (!rb || m_last_b)) begin
            m_st = 1; m_sel = 1'b0; m_last_b = 1'b0; m_held = 1;
          end else if (rb) begin
            m_st = 2; m_sel = 1'b1; m_last_b = 1'b1; m_held = 1;
          end
        end
        1, 2: begin
          mine_req = (m_st == 1) ? ra : rb;
          mine_rel = (m_st == 1) ? la : lb;
          other    = (m_st == 1) ? rb : ra;
          if (mine_rel || !mine_req) begin
            m_st = 3; m_gleft = GUARD_CYC;
          end else if (m_held >= HOLD_MAX && other) begin
            m_st = 3; m_gleft = GUARD_CYC; m_to = 1'b1;
          end else if (m_held < 255) begin
            m_held = m_held + 1;
          end
        end
        default: begin
          m_gleft = m_gleft - 1;
          if (m_gleft == 0) m_st = 0;
        end
      endcase
    end
  endtask

  task automatic step(input string tag, input bit ra, input bit rb, input bit la, input bit lb, input bit rs);
    exp_t e, o;
    @(negedge clk);
    bus.req_a = ra; bus.req_b = rb; bus.rel_a = la; bus.rel_b = lb; rst = rs;
    model_step(ra, rb, la, lb, rs);
    exp_q.push_back({m_st == 1, m_st == 2, m_sel, m_st != 0, m_to});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {bus.gnt_a, bus.gnt_b, bus.sel, bus.busy, bus.timeout};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed gnt_a/gnt_b/sel/busy/timeout=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  initial begin
    bit ra, rb, la, lb, rs;
    bit prev_ga, prev_gb, prev_sel, have_owner, last_owner_b;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.rel_a = 1'b0; bus.rel_b = 1'b0;

    step("reset", 0, 0, 0, 0, 1);
    step("reset", 0, 0, 0, 0, 1);
    chk("reset_gnt_a", bus.gnt_a, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_sel", bus.sel, 1'b0);

    // First tie goes to A, one cycle latency
    step("tie_first", 1, 1, 0, 0, 0);
    chk("tie_gnt_a", bus.gnt_a, 1'b1);
    chk("tie_gnt_b", bus.gnt_b, 1'b0);
    chk("tie_sel", bus.sel, 1'b0);

    // A held with B waiting: forced release on the 9th grant cycle
    for (int i = 0; i < 7; i++) step("hold_a", 1, 1, 0, 0, 0);
    chk("hold8_gnt_a", bus.gnt_a, 1'b1);
    step("force_rel", 1, 1, 0, 0, 0);
    chk("force_timeout", bus.timeout, 1'b1);
    chk("force_gnt_a", bus.gnt_a, 1'b0);
    step("guard_to_idle", 1, 1, 0, 0, 0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_timeout", bus.timeout, 1'b0);
    step("rr_to_b", 1, 1, 0, 0, 0);
    chk("rr_gnt_b", bus.gnt_b, 1'b1);
    chk("rr_sel_b", bus.sel, 1'b1);

    // B drops req; A regains; release coincides with hold limit
    step("b_drop", 1, 0, 0, 0, 0);
    step("guard", 1, 1, 0, 0, 0);
    step("regrant_a", 1, 1, 0, 0, 0);
    chk("regrant_gnt_a", bus.gnt_a, 1'b1);
    for (int i = 0; i < 7; i++) step("hold_a2", 1, 1, 0, 0, 0);
    step("rel_at_limit", 1, 1, 1, 0, 0);
    chk("rel_limit_gnt_a", bus.gnt_a, 1'b0);
    chk("rel_limit_timeout", bus.timeout, 1'b0);

    // Only B requesting: hold indefinitely, counter saturates, then A arrives
    step("drain", 0, 0, 0, 0, 0);
    step("drain", 0, 0, 0, 0, 0);
    step("b_only_grant", 0, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step("b_only", 0, 1, 0, 0, 0);
      chk("b_only_gnt", bus.gnt_b, 1'b1);
      chk("b_only_timeout", bus.timeout, 1'b0);
      chk("b_only_busy", bus.busy, 1'b1);
    end
    step("late_a", 1, 1, 0, 0, 0);
    chk("late_a_timeout", bus.timeout, 1'b1);

    // Foreign release ignored; reset mid-grant
    step("guard2", 1, 0, 0, 0, 0);
    step("grant_a3", 1, 0, 0, 0, 0);
    step("foreign_rel", 1, 0, 0, 1, 0);
    chk("foreign_rel_gnt_a", bus.gnt_a, 1'b1);
    step("rel_a", 0, 1, 1, 0, 0);
    step("guard3", 0, 1, 0, 0, 0);
    step("grant_b3", 0, 1, 0, 0, 0);
    chk("grant_b3_gnt", bus.gnt_b, 1'b1);
    step("rst_in_b", 0, 1, 0, 0, 1);
    chk("rst_b_gnt_b", bus.gnt_b, 1'b0);
    chk("rst_b_sel", bus.sel, 1'b0);
    chk("rst_b_timeout", bus.timeout, 1'b0);

    // Continuous contention must alternate owners
    have_owner = 1'b0; last_owner_b = 1'b0; prev_ga = 1'b0; prev_gb = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step("contend", 1, 1, 0, 0, 0);
      if ((bus.gnt_a && !prev_ga) || (bus.gnt_b && !prev_gb)) begin
        if (have_owner) chk("rr_alternate", bus.gnt_b, ~last_owner_b);
        have_owner   = 1'b1;
        last_owner_b = bus.gnt_b;
      end
      prev_ga = bus.gnt_a; prev_gb = bus.gnt_b;
    end

    // Random streams with invariant checks
    prev_ga = 1'b0; prev_gb = 1'b0; prev_sel = bus.sel;
    for (int i = 0; i < 10000; i++) begin
      ra = ($urandom_range(0, 9) < 7);
      rb = ($urandom_range(0, 9) < 7);
      la = ($urandom_range(0, 9) == 0);
      lb = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step("random", ra, rb, la, lb, rs);
      chk("no_overlap", bus.gnt_a & bus.gnt_b, 1'b0);
      if (!rs && ((prev_ga && bus.gnt_a) || (prev_gb && bus.gnt_b)))
        chk("sel_stable", bus.sel, prev_sel);
      prev_ga = bus.gnt_a; prev_gb = bus.gnt_b; prev_sel = bus.sel;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8, SHALL set the maximum cycles a grant is held while the other requester waits (legal 1..255).
REQ-002 Parameter GUARD_CYC, default 1, SHALL set the dead cycles between any two grants (legal 1..15).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port req_a  input  1  SHALL be requester A's request for the shared mux (mux input a).
REQ-006 Port req_b  input  1  SHALL be requester B's request for the shared mux (mux input b).
REQ-007 Port rel_a  input  1  SHALL be A's voluntary release strobe, honoured only while gnt_a=1.
REQ-008 Port rel_b  input  1  SHALL be B's voluntary release strobe, honoured only while gnt_b=1.
REQ-009 Port gnt_a  output  1  SHALL be the registered grant to A.
REQ-010 Port gnt_b  output  1  SHALL be the registered grant to B.
REQ-011 Port sel  output  1  SHALL drive the mux select: 0 = a, 1 = b.
REQ-012 Port busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-013 Port timeout  output  1  SHALL pulse high for one cycle on a forced release.

Function
REQ-014 FSM states SHALL be IDLE, OWN_A, OWN_B, GUARD; gnt_a=1 only in OWN_A; gnt_b=1 only in OWN_B; gnt_a and gnt_b SHALL never both be 1.
REQ-015 IDLE arbitration: only one req high -> that requester; both high -> the requester not granted last (round-robin pointer); none -> stay IDLE.
REQ-016 Grant latency SHALL be one cycle: req sampled high in IDLE -> gnt high the next cycle.
REQ-017 The last-granted pointer SHALL update on every entry to OWN_A or OWN_B.
REQ-018 sel SHALL change only on entry to OWN_A (->0) or OWN_B (->1); it SHALL hold its value in IDLE and GUARD.
REQ-019 An 8-bit hold counter SHALL load 1 on entry to an OWN state, increment each cycle in it, and saturate at 255.
REQ-020 In OWN_x, rel_x=1 or req_x=0 SHALL end the grant: next state GUARD, gnt_x=0 the next cycle.
REQ-021 In OWN_x, hold counter >= HOLD_MAX with the other req high SHALL force the transition to GUARD and pulse timeout in that same next cycle.
REQ-022 Release and timeout in the same cycle SHALL count as a voluntary release: no timeout pulse.
REQ-023 With the other req low, hold SHALL continue past HOLD_MAX indefinitely, with no timeout.
REQ-024 GUARD SHALL last exactly GUARD_CYC cycles with no grants, then enter IDLE, which arbitrates per REQ-015.
REQ-025 rel_x while not granted to x SHALL be ignored.
REQ-026 A req dropped and re-raised during GUARD SHALL be arbitrated normally in IDLE.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be: FSM IDLE; gnt_a=0, gnt_b=0, sel=0, busy=0, timeout=0; counters 0; pointer "B last" so A wins the first tie.
REQ-028 rst asserted mid-grant SHALL drop the grant the next cycle with no timeout pulse.

Verification
REQ-029 Reset, then req_a=req_b=1 at cycle 0 -> gnt_a=1, sel=0 at cycle 1; gnt_b=0.
REQ-030 A holds with req_b=1, HOLD_MAX=8, GUARD_CYC=1 -> timeout=1 and gnt_a=0 at the 9th grant cycle; GUARD for 1 cycle; IDLE for 1 cycle; gnt_b=1, sel=1 on the next cycle.
REQ-031 A granted, rel_a=1 at the same cycle the count reaches HOLD_MAX -> gnt_a drops, timeout stays 0.
REQ-032 Only req_b=1 for 50 cycles -> gnt_b held throughout, timeout never asserted, busy=1.
REQ-033 rel_b=1 while gnt_a=1 -> no effect; rst=1 during OWN_B -> all outputs 0 next cycle, sel=0.
REQ-034 Random req/rel streams over 10k cycles -> grants never overlap, sel never changes while a grant is high, and round-robin alternates under continuous contention.
